// File: rtl/fifo_fill_ctrl.sv
// FIFO refill controller: IDLE/FILL/HOLD hysteresis between low and high watermarks,
// with stall detection. Define FIFO_FILL_CTRL_BURST_CNT_EN to build the FILL-entry counter.
module fifo_fill_ctrl #(
    parameter int LVL_W     = 8,
    parameter int STALL_LIM = 16,
    parameter int CNT_W     = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEnable,
    input  logic             iEmpty,
    input  logic             iFull,
    input  logic [LVL_W-1:0] iLevel,
    input  logic [LVL_W-1:0] iLowMark,
    input  logic [LVL_W-1:0] iHighMark,
    input  logic             iClrStall,
    output logic             oFIFO_WR_EN,
    output logic [1:0]       oState,
    output logic             oStall,
    output logic             oCfgErr,
    output logic [CNT_W-1:0] oBurstCnt
);

    localparam int SC_W = $clog2(STALL_LIM + 1);
    localparam logic [SC_W-1:0] STALL_LIM_C = SC_W'(STALL_LIM);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FILL    = 2'b01,
        HOLD    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t           state_r;
    state_t           nextState_s;
    logic [SC_W-1:0]  stallCnt_r;
    logic [SC_W-1:0]  stallCntNext_s;
    logic [LVL_W-1:0] prevLevel_r;
    logic             stall_r;
    logic             stallHit_s;
    logic             refillReq_s;
    logic             cfgErr_s;

    // Watermark sanity and the shared "FIFO wants refilling" condition.
    always_comb begin
        cfgErr_s    = (iLowMark >= iHighMark);
        refillReq_s = !iFull && (iEmpty || (iLevel <= iLowMark));
    end

    // Stall run length: counts FILL cycles whose level matches the previous sample.
    always_comb begin
        stallCntNext_s = {SC_W{1'b0}};
        if (state_r == FILL) begin
            if (iLevel == prevLevel_r) begin
                if (stallCnt_r != STALL_LIM_C) begin
                    stallCntNext_s = stallCnt_r + SC_W'(1);
                end else begin
                    stallCntNext_s = stallCnt_r;
                end
            end else begin
                stallCntNext_s = {SC_W{1'b0}};
            end
        end else begin
            stallCntNext_s = {SC_W{1'b0}};
        end
        stallHit_s = (state_r == FILL) && (stallCntNext_s == STALL_LIM_C);
    end

    // Next-state logic; disable and misconfiguration override everything else.
    always_comb begin
        nextState_s = IDLE;
        if (!iEnable || cfgErr_s) begin
            nextState_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    nextState_s = refillReq_s ? FILL : IDLE;
                FILL:    nextState_s = (iFull || (iLevel >= iHighMark) || stallHit_s) ? HOLD : FILL;
                HOLD:    nextState_s = refillReq_s ? FILL : HOLD;
                default: nextState_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Stall counter, previous-level sample and sticky stall flag (set beats clear).
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stallCnt_r  <= {SC_W{1'b0}};
            prevLevel_r <= {LVL_W{1'b0}};
            stall_r     <= 1'b0;
        end else begin
            stallCnt_r  <= stallCntNext_s;
            prevLevel_r <= iLevel;
            if (stallHit_s) begin
                stall_r <= 1'b1;
            end else if (iClrStall) begin
                stall_r <= 1'b0;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

`ifdef FIFO_FILL_CTRL_BURST_CNT_EN
    logic [CNT_W-1:0] burstCnt_r;
    logic             enterFill_s;

    // A burst starts whenever FILL is entered from IDLE or HOLD.
    always_comb begin
        enterFill_s = (nextState_s == FILL) && ((state_r == IDLE) || (state_r == HOLD));
    end

    // Saturating burst counter.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            burstCnt_r <= {CNT_W{1'b0}};
        end else if (enterFill_s && !(&burstCnt_r)) begin
            burstCnt_r <= burstCnt_r + CNT_W'(1);
        end else begin
            burstCnt_r <= burstCnt_r;
        end
    end

    assign oBurstCnt = burstCnt_r;
`else
    assign oBurstCnt = {CNT_W{1'b0}};
`endif

    // Write enable is gated by iFull directly so it drops in the very cycle the FIFO fills.
    assign oFIFO_WR_EN = (state_r == FILL) && !iFull;
    assign oState      = state_r;
    assign oStall      = stall_r;
    assign oCfgErr     = cfgErr_s;

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl: rule-level model compared every cycle plus directed literal checks.
module tb_fifo_fill_ctrl;

    localparam int LVL_W     = 8;
    localparam int STALL_LIM = 16;
    localparam int CNT_W     = 16;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iEnable;
    logic             iEmpty;
    logic             iFull;
    logic [LVL_W-1:0] iLevel;
    logic [LVL_W-1:0] iLowMark;
    logic [LVL_W-1:0] iHighMark;
    logic             iClrStall;
    logic             oFIFO_WR_EN;
    logic [1:0]       oState;
    logic             oStall;
    logic             oCfgErr;
    logic [CNT_W-1:0] oBurstCnt;

    int nVec = 0;
    int nErr = 0;

    fifo_fill_ctrl #(.LVL_W(LVL_W), .STALL_LIM(STALL_LIM), .CNT_W(CNT_W)) dut (
        .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iEmpty(iEmpty), .iFull(iFull),
        .iLevel(iLevel), .iLowMark(iLowMark), .iHighMark(iHighMark), .iClrStall(iClrStall),
        .oFIFO_WR_EN(oFIFO_WR_EN), .oState(oState), .oStall(oStall), .oCfgErr(oCfgErr),
        .oBurstCnt(oBurstCnt)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: 0=IDLE 1=FILL 2=HOLD, run = consecutive unchanged-level FILL cycles.
    int mState = 0, mRun = 0, mPrev = 0, mStall = 0, mBursts = 0;

    function automatic int runAfter(int st, int run);
        if (st == 1 && int'(iLevel) == mPrev) return (run < STALL_LIM) ? run + 1 : run;
        return 0;
    endfunction

    function automatic int stateAfter(int st, int run1);
        bit wantFill = !iFull && (iEmpty || iLevel <= iLowMark);
        if (!iEnable || iLowMark >= iHighMark) return 0;
        if (st == 0) return wantFill ? 1 : 0;
        if (st == 1) return (iFull || iLevel >= iHighMark || run1 == STALL_LIM) ? 2 : 1;
        if (st == 2) return wantFill ? 1 : 2;
        return 0;
    endfunction

    function automatic int burstsAfter(int st, int ns, int b);
`ifdef FIFO_FILL_CTRL_BURST_CNT_EN
        if (ns == 1 && st != 1 && b < (2 ** CNT_W) - 1) return b + 1;
        return b;
`else
        return 0;
`endif
    endfunction

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mState <= 0; mRun <= 0; mPrev <= 0; mStall <= 0; mBursts <= 0;
        end else begin
            mState  <= stateAfter(mState, runAfter(mState, mRun));
            mRun    <= runAfter(mState, mRun);
            mPrev   <= int'(iLevel);
            mStall  <= (mState == 1 && runAfter(mState, mRun) == STALL_LIM) ? 1 : (iClrStall ? 0 : mStall);
            mBursts <= burstsAfter(mState, stateAfter(mState, runAfter(mState, mRun)), mBursts);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge iClk) begin
        chk("state", 32'(oState), 32'(mState));
        chk("wr_en", 32'(oFIFO_WR_EN), 32'((mState == 1) && !iFull));
        chk("stall", 32'(oStall), 32'(mStall));
        chk("cfg_err", 32'(oCfgErr), 32'(iLowMark >= iHighMark));
        chk("burst_cnt", 32'(oBurstCnt), 32'(mBursts));
    end

    task automatic nextEdge();
        @(posedge iClk);
        #1;
    endtask

    int expBurst3;

    initial begin
`ifdef FIFO_FILL_CTRL_BURST_CNT_EN
        expBurst3 = 3;
`else
        expBurst3 = 0;
`endif
        iRst = 1'b1; iEnable = 1'b0; iEmpty = 1'b1; iFull = 1'b0; iLevel = 8'd0;
        iLowMark = 8'd16; iHighMark = 8'd240; iClrStall = 1'b0;
        repeat (2) nextEdge();
        chk("lit_rst_state", 32'(oState), 32'd0);
        chk("lit_rst_wr", 32'(oFIFO_WR_EN), 32'd0);
        chk("lit_rst_stall", 32'(oStall), 32'd0);
        chk("lit_rst_burst", 32'(oBurstCnt), 32'd0);

        iRst = 1'b0; iEnable = 1'b1;
        nextEdge();
        chk("lit_idle_to_fill", 32'(oState), 32'd1);
        chk("lit_fill_wr", 32'(oFIFO_WR_EN), 32'd1);

        iLevel = 8'd240; iEmpty = 1'b0;
        nextEdge();
        chk("lit_high_to_hold", 32'(oState), 32'd2);
        chk("lit_hold_wr", 32'(oFIFO_WR_EN), 32'd0);

        for (int l = 239; l >= 17; l--) begin
            iLevel = 8'(l);
            nextEdge();
            chk("lit_hysteresis_hold", 32'(oState), 32'd2);
        end
        iLevel = 8'd16;
        nextEdge();
        chk("lit_low_to_fill", 32'(oState), 32'd1);

        iLevel = 8'd200; iFull = 1'b1;
        #1;
        chk("lit_full_wr_same_cycle", 32'(oFIFO_WR_EN), 32'd0);
        nextEdge();
        chk("lit_full_to_hold", 32'(oState), 32'd2);

        iFull = 1'b0; iLevel = 8'd10;
        nextEdge();
        chk("lit_refill", 32'(oState), 32'd1);
        chk("lit_burst3", 32'(oBurstCnt), 32'(expBurst3));

        iLevel = 8'd50;
        repeat (16) nextEdge();
        chk("lit_pre_stall_state", 32'(oState), 32'd1);
        chk("lit_pre_stall_flag", 32'(oStall), 32'd0);
        nextEdge();
        chk("lit_stall_flag", 32'(oStall), 32'd1);
        chk("lit_stall_hold", 32'(oState), 32'd2);
        iClrStall = 1'b1;
        nextEdge();
        iClrStall = 1'b0;
        chk("lit_stall_cleared", 32'(oStall), 32'd0);

        iLevel = 8'd10;
        nextEdge();
        chk("lit_refill2", 32'(oState), 32'd1);
        iEnable = 1'b0;
        nextEdge();
        chk("lit_disable_idle", 32'(oState), 32'd0);
        iEnable = 1'b1;

        iLowMark = 8'd100; iHighMark = 8'd100;
        #1;
        chk("lit_cfg_err", 32'(oCfgErr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            iLevel = (i == 0) ? 8'd0 : (i == 1) ? 8'd50 : (i == 2) ? 8'd100 : 8'd255;
            iEmpty = (i % 2 == 0);
            nextEdge();
            chk("lit_cfg_idle", 32'(oState), 32'd0);
            chk("lit_cfg_wr", 32'(oFIFO_WR_EN), 32'd0);
        end

        iLowMark = 8'd16; iHighMark = 8'd240; iLevel = 8'd0; iEmpty = 1'b1;
        nextEdge();
        chk("lit_fill_before_rst", 32'(oFIFO_WR_EN), 32'd1);
        #2;
        iRst = 1'b1;
        #1;
        chk("lit_async_rst_wr", 32'(oFIFO_WR_EN), 32'd0);
        chk("lit_async_rst_state", 32'(oState), 32'd0);
        chk("lit_async_rst_burst", 32'(oBurstCnt), 32'd0);
        nextEdge();
        iRst = 1'b0;
        nextEdge();
        chk("lit_post_rst_fill", 32'(oState), 32'd1);
        @(negedge iClk);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
